rps_round_master: RTL
=====================

// Module: rps_round_master
// PURPOSE
//  Host-side driver of the engine's start/ready round handshake. Accepts a player move,
//  raises start with user_choice held stable, waits for engine ready, samples engine choice,
//  then drops start (the falling edge commits the engine's learning update).
//  Scores each round (win/loss/tie); stops after MAX_ROUNDS rounds and reports game over.
// PARAMETERS
//  MAX_ROUNDS  60    rounds per game; matches engine history depth
//  CNT_W       6     width of round and score counters; 2**CNT_W must be > MAX_ROUNDS
//  TIMEOUT     1023  max cycles to wait for each ready transition before aborting the round
// PORTS
//  clock         in   1      single clock, rising edge
//  reset         in   1      synchronous, active-high
//  move_valid    in   1      one-cycle pulse: player move available
//  move_in       in   2      00 rock, 01 scissor, 10 paper, 11 illegal
//  eng_ready     in   1      engine result valid; held until start falls
//  eng_choice    in   2      engine move, same encoding; valid while eng_ready=1
//  eng_start     out  1      round request to engine
//  user_choice   out  2      move presented to engine; stable while eng_start=1
//  round_done    out  1      one-cycle pulse: round scored
//  outcome       out  2      last round: 00 tie, 01 player win, 10 engine win
//  last_eng      out  2      engine move of the last scored round
//  wins          out  CNT_W  player wins
//  losses        out  CNT_W  engine wins
//  ties          out  CNT_W  ties
//  rounds        out  CNT_W  scored rounds
//  game_over     out  1      high once rounds==MAX_ROUNDS
//  err_illegal   out  1      one-cycle pulse: move 11 rejected
//  err_timeout   out  1      one-cycle pulse: round aborted on timeout
// BEHAVIOUR
//  Reset: all outputs and counters 0; state IDLE; reset takes priority in any state.
//  FSM, one transition per clock:
//   IDLE:  move_valid and move_in!=11 -> latch user_choice, eng_start<=1, go WAIT_RDY.
//          move_valid and move_in==11 -> err_illegal pulse, stay IDLE.
//          move_valid ignored outside IDLE; not queued.
//   WAIT_RDY: eng_ready=1 -> sample eng_choice into last_eng, go SCORE.
//             timer==TIMEOUT -> eng_start<=0, err_timeout pulse, go DRAIN; round not counted.
//   SCORE: outcome from (user_choice, last_eng). Rock beats scissor, scissor beats paper,
//          paper beats rock; equal moves tie. Increment exactly one of wins/losses/ties
//          plus rounds. Pulse round_done. eng_start<=0. Go DRAIN.
//          eng_choice==11 -> scored as a tie.
//   DRAIN: wait for eng_ready=0 (engine cleared ready on falling start).
//          Then go DONE if rounds==MAX_ROUNDS, else IDLE.
//          timer==TIMEOUT -> err_timeout pulse, go IDLE.
//   DONE:  game_over=1; inputs ignored; exit only via reset.
//  Timer: cleared on every state entry; counts cycles in WAIT_RDY/DRAIN; saturates at TIMEOUT.
//  Latency: start rises 1 cycle after move_valid; round_done 2 cycles after ready is sampled high.
//  eng_start is low for at least 1 cycle between rounds. user_choice holds until the next accepted move.
//  Counters never wrap, since rounds <= MAX_ROUNDS < 2**CNT_W.
// CONFIGURATION
//  RPS_STREAK_EN defined: adds outputs streak[CNT_W] and best_streak[CNT_W].
//   - streak counts consecutive player wins; reset to 0 on any loss or tie.
//   - best_streak = max(best_streak, streak), updated in the same SCORE cycle.
//   - Timeouts leave both unchanged; both are 0 on reset.
//  RPS_STREAK_EN undefined: these ports and their logic are absent; all other behaviour is identical.
// TESTING
//  T1 move 00, engine ready after 5 cycles with choice 10
//     -> losses=1, outcome=10, rounds=1, round_done pulse once.
//  T2 move 10 vs engine 01 -> losses++.  Move 01 vs engine 10 -> wins++.
//     Move 00 vs 00 -> ties++.  All 9 pairs checked.
//  T3 move 11 -> err_illegal pulse, eng_start stays 0, counters unchanged.
//     move_valid during WAIT_RDY -> ignored.
//  T4 engine never raises ready -> err_timeout at TIMEOUT+1 cycles after start,
//     eng_start=0, rounds unchanged, next move accepted.
//  T5 play 60 rounds -> game_over=1 after the 60th round_done; 61st move ignored.
//     Reset mid-WAIT_RDY -> all 0, eng_start=0 next cycle.
//  T6 (RPS_STREAK_EN) sequence W,W,W,L,W -> streak=1, best_streak=3.

Source files
------------

// File: rtl/rps_round_master.sv
// Host-side rock/paper/scissor round master that drives the engine start/ready handshake, scores rounds and stops at MAX_ROUNDS.
// Start rises 1 cycle after move_valid and round_done pulses 2 cycles after ready is seen. Optional streak outputs are enabled with RPS_STREAK_EN.
// Moves are not queued: move_valid is honoured only in IDLE, and every ready wait gives up after TIMEOUT cycles.
module rps_round_master #(
  parameter int MAX_ROUNDS = 60,
  parameter int CNT_W      = 6,
  parameter int TIMEOUT    = 1023
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             move_valid,
  input  logic [1:0]       move_in,
  input  logic             eng_ready,
  input  logic [1:0]       eng_choice,
  output logic             eng_start,
  output logic [1:0]       user_choice,
  output logic             round_done,
  output logic [1:0]       outcome,
  output logic [1:0]       last_eng,
  output logic [CNT_W-1:0] wins,
  output logic [CNT_W-1:0] losses,
  output logic [CNT_W-1:0] ties,
  output logic [CNT_W-1:0] rounds,
  output logic             game_over,
  output logic             err_illegal,
  output logic             err_timeout
`ifdef RPS_STREAK_EN
  ,
  output logic [CNT_W-1:0] streak,
  output logic [CNT_W-1:0] best_streak
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, SCORE, DRAIN, DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [1:0]    score;
  logic          timer_hit;
  logic          last_round;

  assign timer_hit  = (timer == TW'(TIMEOUT));
  assign last_round = (rounds == CNT_W'(MAX_ROUNDS));

  // An illegal engine move (11) falls through to the default and scores as a tie.
  always_comb begin
    score = 2'b00;
    case ({user_choice, last_eng})
      4'b0001, 4'b0110, 4'b1000: score = 2'b01;
      4'b0010, 4'b0100, 4'b1001: score = 2'b10;
      default:                   score = 2'b00;
    endcase
  end

`ifdef RPS_STREAK_EN
  logic [CNT_W-1:0] streak_nxt;
  assign streak_nxt = streak + CNT_W'(1);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      eng_start   <= 1'b0;
      user_choice <= 2'b00;
      round_done  <= 1'b0;
      outcome     <= 2'b00;
      last_eng    <= 2'b00;
      wins        <= '0;
      losses      <= '0;
      ties        <= '0;
      rounds      <= '0;
      game_over   <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
`ifdef RPS_STREAK_EN
      streak      <= '0;
      best_streak <= '0;
`endif
    end else begin
      round_done  <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (move_valid) begin
            if (move_in == 2'b11) begin
              err_illegal <= 1'b1;
            end else begin
              user_choice <= move_in;
              eng_start   <= 1'b1;
              timer       <= '0;
              state       <= WAIT_RDY;
            end
          end
        end
        WAIT_RDY: begin
          if (eng_ready) begin
            last_eng <= eng_choice;
            timer    <= '0;
            state    <= SCORE;
          end else if (timer_hit) begin
            eng_start   <= 1'b0;
            err_timeout <= 1'b1;
            timer       <= '0;
            state       <= DRAIN;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        SCORE: begin
          outcome    <= score;
          rounds     <= rounds + CNT_W'(1);
          round_done <= 1'b1;
          eng_start  <= 1'b0;
          timer      <= '0;
          state      <= DRAIN;
          case (score)
            2'b01:   wins   <= wins + CNT_W'(1);
            2'b10:   losses <= losses + CNT_W'(1);
            default: ties   <= ties + CNT_W'(1);
          endcase
`ifdef RPS_STREAK_EN
          if (score == 2'b01) begin
            streak <= streak_nxt;
            if (streak_nxt > best_streak) best_streak <= streak_nxt;
          end else begin
            streak <= '0;
          end
`endif
        end
        DRAIN: begin
          // The engine commits its learning update on falling start and then clears ready.
          if (!eng_ready) begin
            timer     <= '0;
            game_over <= last_round;
            state     <= last_round ? DONE : IDLE;
          end else if (timer_hit) begin
            err_timeout <= 1'b1;
            timer       <= '0;
            state       <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          game_over <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
